// File: rtl/adc_ctrl.sv
// Dual-channel ADC front-end controller: power sequencing (OFF/WAKE/FLUSH/RUN)
// and a single-register valid/ready sample output stage with a sticky drop flag.
module adc_ctrl #(
    parameter int WAKE_CYC = 1024,
    parameter int PIPE_LAT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [11:0] DATA_A,
    input  logic [11:0] DATA_B,
    input  logic        OTR_A,
    input  logic        OTR_B,
    output logic        PDWN_A,
    output logic        PDWN_B,
    output logic        OEB_A,
    output logic        OEB_B,
    output logic        DCS,
    output logic        DFS,
    output logic [11:0] smp_data,
    output logic        smp_ch,
    output logic        smp_otr,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic        busy,
    output logic        ovf,
    input  logic        ovf_clr
);

    localparam int WAKE_N  = (WAKE_CYC > 1) ? WAKE_CYC - 1 : 0;
    localparam int PIPE_N  = (PIPE_LAT > 1) ? PIPE_LAT - 1 : 0;
    localparam int CNT_MAX = (WAKE_N > PIPE_N) ? WAKE_N : PIPE_N;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_N);
    localparam logic [CW-1:0] PIPE_LD = CW'(PIPE_N);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    mode_r;
    logic          tog_r;

    logic          cap_s;
    logic          ch_s;
    logic [1:0]    mode_in_s;
    logic [11:0]   word_s;
    logic          otr_s;

    function automatic logic sel_a(input logic [1:0] m);
        return (m != 2'b01);
    endfunction

    function automatic logic sel_b(input logic [1:0] m);
        return (m == 2'b01) || (m == 2'b10);
    endfunction

    assign DCS = 1'b1;
    assign DFS = 1'b1;

    // Capture strobe and channel/data selection; the FLUSH-to-RUN edge already captures.
    always_comb begin
        cap_s     = 1'b0;
        ch_s      = 1'b0;
        mode_in_s = 2'b00;
        if (en && ((state_r == RUN) || ((state_r == FLUSH) && (cnt_r == CNT_ZERO)))) begin
            cap_s = 1'b1;
        end else begin
            cap_s = 1'b0;
        end
        case (mode_r)
            2'b01:   ch_s = 1'b1;
            2'b10:   ch_s = tog_r;
            default: ch_s = 1'b0;
        endcase
        if (mode == 2'b11) begin
            mode_in_s = 2'b00;
        end else begin
            mode_in_s = mode;
        end
    end

    assign word_s = ch_s ? DATA_B : DATA_A;
    assign otr_s  = ch_s ? OTR_B : OTR_A;

    // Power-sequencing FSM with registered power-down / output-enable controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= OFF;
            cnt_r   <= CNT_ZERO;
            mode_r  <= 2'b00;
            tog_r   <= 1'b0;
            busy    <= 1'b0;
            PDWN_A  <= 1'b1;
            PDWN_B  <= 1'b1;
            OEB_A   <= 1'b1;
            OEB_B   <= 1'b1;
        end else if ((state_r != OFF) && !en) begin
            state_r <= OFF;
            cnt_r   <= CNT_ZERO;
            busy    <= 1'b0;
            PDWN_A  <= 1'b1;
            PDWN_B  <= 1'b1;
            OEB_A   <= 1'b1;
            OEB_B   <= 1'b1;
        end else begin
            case (state_r)
                OFF: begin
                    if (en) begin
                        state_r <= WAKE;
                        mode_r  <= mode_in_s;
                        cnt_r   <= WAKE_LD;
                        tog_r   <= 1'b0;
                        busy    <= 1'b1;
                        PDWN_A  <= ~sel_a(mode_in_s);
                        PDWN_B  <= ~sel_b(mode_in_s);
                    end else begin
                        state_r <= OFF;
                    end
                end
                WAKE: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= FLUSH;
                        cnt_r   <= PIPE_LD;
                        OEB_A   <= ~sel_a(mode_r);
                        OEB_B   <= ~sel_b(mode_r);
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                FLUSH: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= RUN;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                RUN: begin
                    state_r <= RUN;
                end
                default: begin
                    state_r <= OFF;
                    cnt_r   <= CNT_ZERO;
                    busy    <= 1'b0;
                    PDWN_A  <= 1'b1;
                    PDWN_B  <= 1'b1;
                    OEB_A   <= 1'b1;
                    OEB_B   <= 1'b1;
                end
            endcase
            // Alternation advances on every capture, including dropped ones.
            if (cap_s) begin
                tog_r <= ~tog_r;
            end
        end
    end

    // Single-register output stage with sticky overflow on dropped samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_valid <= 1'b0;
            smp_data  <= 12'h000;
            smp_ch    <= 1'b0;
            smp_otr   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (cap_s && (!smp_valid || smp_ready)) begin
                smp_valid <= 1'b1;
                smp_data  <= word_s;
                smp_ch    <= ch_s;
                smp_otr   <= otr_s;
            end else if (smp_valid && smp_ready) begin
                smp_valid <= 1'b0;
            end else begin
                smp_valid <= smp_valid;
            end
            if (cap_s && smp_valid && !smp_ready) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end else begin
                ovf <= ovf;
            end
        end
    end

endmodule

// File: doc/adc_ctrl.md
ADC_CTRL -- requirements
Module: adc_ctrl

Interface
REQ-001 Parameter WAKE_CYC, default 1024: ADC power-up settle time, clk cycles.
REQ-002 Parameter PIPE_LAT, default 7: samples discarded after outputs enable (converter pipeline flush).
REQ-003 clk  in  1  sample clock; all logic on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 en  in  1  capture enable; level-sensitive.
REQ-006 mode  in  2  00 = A only, 01 = B only, 10 = alternate A/B, 11 = treated as 00.
REQ-007 DATA_A, DATA_B  in  12 each  converter output words, two's complement.
REQ-008 OTR_A, OTR_B  in  1 each  converter over-range flags.
REQ-009 PDWN_A, PDWN_B  out  1 each  1 = channel powered down.
REQ-010 OEB_A, OEB_B  out  1 each  1 = converter outputs high-Z.
REQ-011 DCS, DFS  out  1 each  constant 1 (duty-cycle stabiliser on, two's complement format).
REQ-012 smp_data  out  12  sample word; smp_ch  out  1  0 = A, 1 = B; smp_otr  out  1  over-range flag of the sample.
REQ-013 smp_valid  out  1 / smp_ready  in  1  valid/ready output handshake.
REQ-014 busy  out  1  high in any state other than OFF.
REQ-015 ovf  out  1  sticky sample-drop flag; ovf_clr  in  1  clears it synchronously.

Function
REQ-016 FSM states OFF, WAKE, FLUSH, RUN.
- OFF: PDWN_A = PDWN_B = 1, OEB_A = OEB_B = 1.
- en = 1 in OFF: latch mode into an internal register, load the counter with WAKE_CYC-1, go to WAKE.
REQ-017 WAKE: PDWN of each selected channel = 0 (both channels for mode 10); OEB stays 1; the counter decrements each cycle; at 0, load PIPE_LAT-1 and go to FLUSH.
REQ-018 FLUSH: OEB of each selected channel = 0; input samples are ignored; the counter decrements; at 0, go to RUN.
REQ-019 RUN: one input sample is captured every clk edge.
- Modes 00 and 01: channel fixed.
- Mode 10: the first sample is from A, then the channel toggles every cycle.
REQ-020 Deselected channels SHALL keep PDWN = 1 and OEB = 1 in every state.
REQ-021 en = 0 in any non-OFF state returns the FSM to OFF on the next edge. The counter clears. A pending valid sample is retained until it is accepted.
REQ-022 Changes to mode while busy = 1 are ignored; they take effect only on the next OFF-to-WAKE transition.
REQ-023 Output stage: single register.
- The input sampled at edge k is loaded into smp_data, smp_ch and smp_otr, with smp_valid = 1, at edge k, if smp_valid = 0 or smp_ready = 1.
- Latency is 1 cycle from input to output.
REQ-024 Handshake: a transfer occurs when smp_valid and smp_ready are both 1 at an edge.
- With no new sample at that edge, smp_valid falls to 0.
- smp_data is held stable while smp_valid = 1 and smp_ready = 0.
REQ-025 Back-pressure: in RUN, if smp_valid = 1 and smp_ready = 0 at an edge, the new sample is dropped and ovf is set to 1. The mode-10 channel toggle still advances.
REQ-026 ovf_clr and a new drop in the same cycle: the set wins, so ovf = 1.
REQ-027 WAKE_CYC or PIPE_LAT = 0 SHALL be treated as 1; the counter never wraps below 0.

Reset
REQ-028 rst = 1 forces the following asynchronously:
- FSM = OFF, counter = 0, latched mode = 00;
- smp_valid = 0, smp_data = 0, smp_ch = 0, smp_otr = 0, ovf = 0, busy = 0;
- PDWN_A = PDWN_B = 1, OEB_A = OEB_B = 1.
REQ-029 Reset asserted mid-RUN discards any pending sample. After release, the FSM stays in OFF until en is sampled as 1.

Verification (bench uses WAKE_CYC = 4, PIPE_LAT = 2)
REQ-030 Mode 00, en = 1, smp_ready = 1, with DATA_A incrementing from 0x000:
- PDWN_A falls 1 edge after en;
- OEB_A falls 4 edges after that;
- the first smp_valid occurs 2 edges later, with smp_ch = 0;
- consecutive smp_data values differ by 1.
REQ-031 Mode 10, DATA_A = 0x111, DATA_B = 0x222:
- the RUN output alternates 0x111/ch 0 and 0x222/ch 1;
- PDWN_A = PDWN_B = 0 in WAKE.
REQ-032 Mode 00 in RUN, smp_ready held 0 for 3 cycles:
- smp_data is frozen at its first value and ovf = 1;
- after smp_ready = 1 and ovf_clr, streaming resumes and ovf = 0.
REQ-033 en dropped mid-RUN with smp_ready = 0:
- FSM returns to OFF; PDWN and OEB return to 1;
- smp_valid stays 1 until smp_ready = 1, then falls to 0.
REQ-034 rst pulsed during WAKE, then mode = 01 and en = 1:
- all outputs are at their reset values immediately;
- the sequence restarts with PDWN_B falling and PDWN_A staying 1.
REQ-035 mode changed from 00 to 01 during RUN: output remains channel A until en is cycled.
